// File: rtl/piano.sv
// Electronic piano top level: key/octave decode, square-wave tone generator,
// auto-play sequencer and scanned dot-matrix / seven-segment display drivers.
module piano #(
    parameter int CLK_HZ      = 1_000_000,
    parameter int SCAN_CYCLES = CLK_HZ / 1000,
    parameter int BEAT_CYCLES = CLK_HZ / 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] Switch,
    input  logic [6:0] Key,
    output logic       Beep,
    output logic [7:0] ROW,
    output logic [7:0] COL_RED,
    output logic [7:0] COL_GREEN,
    output logic [6:0] SEG,
    output logic [7:0] SEG_Neg
);

    localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
    localparam int BEAT_W = $clog2(BEAT_CYCLES + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [6:0] SEG_A = 7'h77;

    localparam int FREQ [21] = '{
        262,  294,  330,  349,  392,  440,  494,
        523,  587,  659,  698,  784,  880,  988,
        1047, 1175, 1319, 1397, 1568, 1760, 1976
    };
    localparam logic [2:0] SONG [16] = '{
        3'd1, 3'd1, 3'd5, 3'd5, 3'd6, 3'd6, 3'd5, 3'd0,
        3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd0
    };

    typedef enum logic [1:0] {
        OCT_IDLE = 2'd0,
        OCT_LOW  = 2'd1,
        OCT_MID  = 2'd2,
        OCT_HIGH = 2'd3
    } octave_e;

    // Rounded half-periods, folded to constants at elaboration time.
    logic [15:0] half_tbl [21];
    for (genvar g = 0; g < 21; g++) begin : g_half
        assign half_tbl[g] = 16'((CLK_HZ + FREQ[g]) / (2 * FREQ[g]));
    end

    function automatic logic [6:0] seg_digit(input logic [2:0] d);
        case (d)
            3'd1:    return 7'h30;
            3'd2:    return 7'h6D;
            3'd3:    return 7'h79;
            3'd4:    return 7'h33;
            3'd5:    return 7'h5B;
            3'd6:    return 7'h5F;
            3'd7:    return 7'h70;
            default: return 7'h00;
        endcase
    endfunction

    octave_e           oct_q, oct_d;
    logic [2:0]        note_q, note_d, key_note;
    logic              auto_q, auto_d, changed;
    logic [3:0]        step_q, step_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [15:0]       tone_cnt_q, tone_cnt_d, half_period;
    logic [4:0]        tbl_idx;
    logic              beep_q, beep_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        row_idx_q, row_idx_d;
    logic              digit_q, digit_d;
    logic [7:0]        bar;
    logic [7:0]        row_q, row_d, col_red_q, col_red_d, col_green_q, col_green_d;
    logic [7:0]        seg_neg_q, seg_neg_d;
    logic [6:0]        seg_q, seg_d;

    // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        key_note = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (Key[i]) key_note = 3'(7 - i);
        end
        auto_d = 1'b0;
        oct_d  = OCT_IDLE;
        note_d = 3'd0;
        if (Switch[3]) begin
            auto_d = 1'b1;
            oct_d  = OCT_MID;
            note_d = SONG[step_q];
        end else if (Switch[2]) begin
            oct_d  = OCT_HIGH;
            note_d = key_note;
        end else if (Switch[1]) begin
            oct_d  = OCT_MID;
            note_d = key_note;
        end else if (Switch[0]) begin
            oct_d  = OCT_LOW;
            note_d = key_note;
        end
        changed = (note_d != note_q) || (oct_d != oct_q) || (auto_d != auto_q);
    end

    always_comb begin
        step_d     = step_q;
        beat_cnt_d = beat_cnt_q;
        if (!auto_d) begin
            step_d     = 4'd0;
            beat_cnt_d = '0;
        end else if (beat_cnt_q == BEAT_LAST) begin
            step_d     = step_q + 4'd1;
            beat_cnt_d = '0;
        end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
    end

    // A zero half-period marks rest or idle and holds the buzzer low.
    always_comb begin
        tbl_idx     = 5'(({3'b000, oct_q} - 5'd1) * 5'd7 + {2'b00, note_q} - 5'd1);
        half_period = 16'd0;
        if (note_q != 3'd0 && oct_q != OCT_IDLE) half_period = half_tbl[tbl_idx];
        tone_cnt_d = tone_cnt_q + 16'd1;
        beep_d     = beep_q;
        if (changed || half_period == 16'd0) begin
            tone_cnt_d = 16'd0;
            beep_d     = 1'b0;
        end else if (tone_cnt_q == half_period - 16'd1) begin
            tone_cnt_d = 16'd0;
            beep_d     = ~beep_q;
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        row_idx_d  = row_idx_q;
        digit_d    = digit_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            row_idx_d  = row_idx_q + 3'd1;
            digit_d    = ~digit_q;
        end
        row_d = ~(8'b1 << row_idx_d);
        bar   = 8'h00;
        if (note_q != 3'd0 && oct_q != OCT_IDLE && row_idx_d < note_q) bar = 8'b1 << (note_q - 3'd1);
        col_red_d   = (oct_q == OCT_LOW || oct_q == OCT_HIGH) ? bar : 8'h00;
        col_green_d = (oct_q == OCT_MID || oct_q == OCT_HIGH) ? bar : 8'h00;
        if (oct_q == OCT_IDLE) begin
            seg_d     = 7'h00;
            seg_neg_d = 8'hFF;
        end else if (!digit_d) begin
            seg_d     = seg_digit(note_q);
            seg_neg_d = 8'hFE;
        end else begin
            seg_d     = auto_q ? SEG_A : seg_digit({1'b0, oct_q});
            seg_neg_d = 8'hFD;
        end
    end

    // NOTE: all state lives in this one always_ff and is written only with <=.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            oct_q       <= OCT_IDLE;
            note_q      <= 3'd0;
            auto_q      <= 1'b0;
            step_q      <= 4'd0;
            beat_cnt_q  <= '0;
            tone_cnt_q  <= 16'd0;
            beep_q      <= 1'b0;
            scan_cnt_q  <= '0;
            row_idx_q   <= 3'd0;
            digit_q     <= 1'b0;
            row_q       <= 8'hFE;
            col_red_q   <= 8'h00;
            col_green_q <= 8'h00;
            seg_q       <= 7'h00;
            seg_neg_q   <= 8'hFF;
        end else begin
            oct_q       <= oct_d;
            note_q      <= note_d;
            auto_q      <= auto_d;
            step_q      <= step_d;
            beat_cnt_q  <= beat_cnt_d;
            tone_cnt_q  <= tone_cnt_d;
            beep_q      <= beep_d;
            scan_cnt_q  <= scan_cnt_d;
            row_idx_q   <= row_idx_d;
            digit_q     <= digit_d;
            row_q       <= row_d;
            col_red_q   <= col_red_d;
            col_green_q <= col_green_d;
            seg_q       <= seg_d;
            seg_neg_q   <= seg_neg_d;
        end
    end

    assign Beep      = beep_q;
    assign ROW       = row_q;
    assign COL_RED   = col_red_q;
    assign COL_GREEN = col_green_q;
    assign SEG       = seg_q;
    assign SEG_Neg   = seg_neg_q;

endmodule

// File: tb/tb_piano.sv
// Directed bench for piano: tone half-periods, display scan contents,
// auto-play sequence and reset behaviour against hand-computed values.
module tb_piano;

    localparam int CLK_HZ = 1_000_000;
    localparam int SCAN   = 10;
    localparam int BEAT   = 100;

    localparam int MID_H [7] = '{956, 852, 759, 716, 638, 568, 506};
    localparam int SONG  [16] = '{1, 1, 5, 5, 6, 6, 5, 0, 4, 4, 3, 3, 2, 2, 1, 0};

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] Switch = 4'd0;
    logic [6:0] Key = 7'd0;
    logic       Beep;
    logic [7:0] ROW, COL_RED, COL_GREEN, SEG_Neg;
    logic [6:0] SEG;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    piano #(.CLK_HZ(CLK_HZ), .SCAN_CYCLES(SCAN), .BEAT_CYCLES(BEAT)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .Switch   (Switch),
        .Key      (Key),
        .Beep     (Beep),
        .ROW      (ROW),
        .COL_RED  (COL_RED),
        .COL_GREEN(COL_GREEN),
        .SEG      (SEG),
        .SEG_Neg  (SEG_Neg)
    );

    always #5 CLK = ~CLK;

    // Edges since the last reset edge; fixes the scan phase of the model.
    always @(posedge CLK) cyc <= RST_N ? cyc + 1 : 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            1:       return 7'h30;
            2:       return 7'h6D;
            3:       return 7'h79;
            4:       return 7'h33;
            5:       return 7'h5B;
            6:       return 7'h5F;
            7:       return 7'h70;
            default: return 7'h00;
        endcase
    endfunction

    // Expected {ROW, COL_RED, COL_GREEN, SEG, SEG_Neg}; oct 0 = idle, auto uses oct 2.
    function automatic logic [63:0] disp_model(input int oct, input int note, input bit auto_m, input int c);
        int         row = (c / SCAN) % 8;
        int         dig = (c / SCAN) % 2;
        logic [7:0] rowv = ~(8'(1) << row);
        logic [7:0] col = 8'h00;
        logic [7:0] red, green, neg;
        logic [6:0] seg;
        if (oct != 0 && note != 0 && row < note) col = 8'(1) << (note - 1);
        red   = (oct == 1 || oct == 3) ? col : 8'h00;
        green = (oct == 2 || oct == 3) ? col : 8'h00;
        if (oct == 0) begin
            seg = 7'h00; neg = 8'hFF;
        end else if (dig == 0) begin
            seg = seg_of(note); neg = 8'hFE;
        end else begin
            seg = auto_m ? 7'h77 : seg_of(oct); neg = 8'hFD;
        end
        return {25'd0, rowv, red, green, seg, neg};
    endfunction

    task automatic display_check(input string tag, input int n, input int oct, input int note, input bit auto_m);
        repeat (n) begin
            @(negedge CLK);
            check(tag, {25'd0, ROW, COL_RED, COL_GREEN, SEG, SEG_Neg}, disp_model(oct, note, auto_m, cyc));
        end
    endtask

    // Counts falling edges until Beep equals lvl; bounded so a dead tone still ends.
    task automatic wait_level(input logic lvl, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (Beep !== lvl && n < 5000);
    endtask

    task automatic measure_half(input string tag, input int exp);
        int n;
        wait_level(1'b0, n);
        wait_level(1'b1, n);
        wait_level(1'b0, n);
        check(tag, 64'(n), 64'(exp));
    endtask

    initial begin
        int n;
        int hi;
        repeat (3) @(negedge CLK);
        check("rst_beep", 64'(Beep), 64'd0);
        check("rst_out", {25'd0, ROW, COL_RED, COL_GREEN, SEG, SEG_Neg}, {25'd0, 8'hFE, 8'h00, 8'h00, 7'h00, 8'hFF});

        RST_N = 1'b1; Switch = 4'b0001; Key = 7'b1000000;
        wait_level(1'b1, n);
        check("low_do_first_toggle", 64'(n), 64'd1909);
        wait_level(1'b0, n);
        check("low_do_half", 64'(n), 64'd1908);
        display_check("low_do_disp", 8 * SCAN, 1, 1, 1'b0);

        Switch = 4'b0010;
        for (int i = 0; i < 7; i++) begin
            Key = 7'b1000000 >> i;
            measure_half($sformatf("mid_half_%0d", i + 1), MID_H[i]);
            display_check($sformatf("mid_disp_%0d", i + 1), 8 * SCAN, 2, i + 1, 1'b0);
        end

        Switch = 4'b0100; Key = 7'b0000001;
        measure_half("high_si_half", 253);
        display_check("high_si_disp", 8 * SCAN, 3, 7, 1'b0);
        Key = 7'b1100000;
        measure_half("high_do_half", 478);

        wait_level(1'b1, n);
        Key = 7'b0000000;
        repeat (2) @(negedge CLK);
        check("rest_beep", 64'(Beep), 64'd0);
        hi = 0;
        repeat (600) begin
            @(negedge CLK);
            if (Beep) hi = 1;
        end
        check("rest_quiet", 64'(hi), 64'd0);
        display_check("rest_disp", 8 * SCAN, 3, 0, 1'b0);

        Key = 7'b1000000;
        wait_level(1'b1, n);
        Switch = 4'b0000;
        repeat (2) @(negedge CLK);
        check("idle_beep", 64'(Beep), 64'd0);
        display_check("idle_disp", 8 * SCAN, 0, 0, 1'b0);

        Switch = 4'b1000; Key = 7'b0000001;
        for (int k = 0; k < 17; k++) begin
            repeat (9) @(negedge CLK);
            repeat (80) begin
                @(negedge CLK);
                check($sformatf("auto_disp_%0d", k), {25'd0, ROW, COL_RED, COL_GREEN, SEG, SEG_Neg},
                      disp_model(2, SONG[k % 16], 1'b1, cyc));
                if (SONG[k % 16] == 0) check($sformatf("auto_rest_%0d", k), 64'(Beep), 64'd0);
            end
            repeat (11) @(negedge CLK);
        end
        repeat (150) @(negedge CLK);
        Switch = 4'b0001;
        repeat (5) @(negedge CLK);
        Switch = 4'b1000;
        repeat (9) @(negedge CLK);
        display_check("auto_restart", 80, 2, 1, 1'b1);

        Switch = 4'b0100; Key = 7'b0000001;
        wait_level(1'b1, n);
        RST_N = 1'b0;
        @(negedge CLK);
        check("midrst_beep", 64'(Beep), 64'd0);
        check("midrst_out", {25'd0, ROW, COL_RED, COL_GREEN, SEG, SEG_Neg}, {25'd0, 8'hFE, 8'h00, 8'h00, 7'h00, 8'hFF});
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        wait_level(1'b1, n);
        check("postrst_first_toggle", 64'(n), 64'd254);
        wait_level(1'b0, n);
        check("postrst_half", 64'(n), 64'd253);
        display_check("postrst_disp", 8 * SCAN, 3, 7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/piano.md
# piano

Electronic piano top level: seven note keys and an octave/mode switch drive a square-wave tone on a buzzer. The current note is shown on an 8x8 red/green dot matrix and on multiplexed seven-segment digits. A built-in auto-play mode loops a stored tune. It sits at the board top level, directly on pins.

## Interface
- CLK_HZ, 1_000_000: system clock frequency; all dividers derive from it.
- SCAN_CYCLES, CLK_HZ/1000: clocks per matrix row and per display digit slot.
- BEAT_CYCLES, CLK_HZ/4: clocks per auto-play step.

- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  synchronous active-low reset.
- Switch  in  4  mode: [0] low octave, [1] mid octave, [2] high octave, [3] auto-play.
- Key  in  7  note keys, active high: [6]=Do(1) … [0]=Si(7).
- Beep  out  1  square-wave tone to buzzer.
- ROW  out  8  matrix row select, active low, one-hot scan; [0] = bottom row.
- COL_RED  out  8  red column drive, active high; [0] = leftmost.
- COL_GREEN  out  8  green column drive, active high.
- SEG  out  7  segments {a,b,c,d,e,f,g}, active high.
- SEG_Neg  out  8  digit enables, active low.

## Operation
- Mode decode priority: Switch[3] > [2] > [1] > [0]. Switch=0 is idle: silent, display blank.
- Manual modes: the selected octave is 1 (low), 2 (mid) or 3 (high). Note = index of the highest set Key bit (Key[6] wins), mapped to 1..7. Key=0 gives note 0 (rest).
- Auto mode: Key is ignored. A 16-step ROM plays mid octave: 1,1,5,5,6,6,5,0,4,4,3,3,2,2,1,0 (0 = rest).
  - Each step lasts BEAT_CYCLES. After step 15 it wraps to step 0.
  - Leaving auto mode resets the step pointer to 0.
- Tone: half-period H = round(CLK_HZ / (2·f)). Beep toggles every H clocks.
  - Low octave Do..Si: 262, 294, 330, 349, 392, 440, 494 Hz.
  - Mid octave: 523, 587, 659, 698, 784, 880, 988 Hz.
  - High octave: 1047, 1175, 1319, 1397, 1568, 1760, 1976 Hz.
  - Tone counter width is 16 bits.
  - When note or octave changes, the counter clears and Beep restarts low.
  - On rest or idle, Beep is held 0.
- Dot matrix: bar graph for note n (1..7).
  - Column n-1 lights rows 0..n-1.
  - Colour: red for low, green for mid, both (yellow) for high. Auto mode uses green.
  - Rest or idle: all columns 0.
  - The row scan advances one row every SCAN_CYCLES, sequence 0→7→0. Columns output only the lit pixels of the active row.
- Seven-segment: digit 0 (SEG_Neg[0]) shows the note digit 1..7, blank for rest.
  - Digit 1 (SEG_Neg[1]) shows the octave digit 1/2/3, or 'A' (a,b,c,e,f,g) in auto mode.
  - The two digits alternate every SCAN_CYCLES. SEG_Neg[7:2] are always 1.
  - Idle mode: SEG=0 and SEG_Neg=8'hFF.

## Timing
- Reset values (RST_N=0 at a rising edge):
  - Beep=0, ROW=8'hFE (row 0 selected), COL_RED=COL_GREEN=0, SEG=0, SEG_Neg=8'hFF.
  - All counters 0, auto step 0.
- Switch and Key are sampled every clock with no debounce. The decoded note is registered, giving 1 cycle latency to the note register.
- Beep first toggles H clocks after the note register changes.
- Matrix and segment outputs are registered. They reflect a new note within 1 cycle of the note register update, on the currently scanned row/digit.
- Auto-play: step k's note is active from cycle k·BEAT_CYCLES (relative to entering auto) for BEAT_CYCLES clocks.
- Reset asserted mid-tone or mid-song: outputs return to reset values on that edge. Operation resumes from step 0 after release.
- Simultaneous mode and key change: the new mode/key pair is decoded together in the same cycle.

## Test plan
- Reset, then Switch=0001, Key=1000000 (CLK_HZ=1e6):
  - Beep toggles every 1908 clocks.
  - Digit 0 shows '1', digit 1 shows '1'.
  - COL_RED[0]=1 only when row 0 is scanned; COL_GREEN=0.
- Switch=0010 with Key stepped 1000000→0000001:
  - Half-periods are 956, 852, 759, 716, 638, 568, 506.
  - Green bar heights are 1..7.
- Switch=0100, Key=0000001:
  - H=253.
  - Row 0..6 lit yellow in column 6.
  - Key=1100000 plays Do (H=478).
- Key=0 or Switch=0:
  - Beep=0 within 2 clocks.
  - Matrix columns 0.
  - Idle additionally gives SEG_Neg=8'hFF.
- Switch=1000 with BEAT_CYCLES=100:
  - Steps follow the ROM sequence.
  - Steps 7 and 15 are silent.
  - Step 16 wraps to Do.
  - Digit 1 shows 'A'.
- Assert RST_N=0 mid-tone: all outputs reach reset values on the next edge, and the tone restarts cleanly after release.
